// File: rtl/digital_lock_fsm.sv
// Keypad lock FSM: enrol a code (enter + confirm), lock/unlock, wrong-code counter with timed lockout.
// Optional idle timeout of partial entries is enabled by defining DIGITAL_LOCK_TIMEOUT_EN.
module digital_lock_fsm #(
  parameter int KEY_WIDTH       = 4,
  parameter int PASSWORD_LENGTH = 4,
  parameter int MAX_ATTEMPTS    = 3,
  parameter int LOCKOUT_CYCLES  = 1000,
  parameter int TIMEOUT_CYCLES  = 5000
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic [KEY_WIDTH-1:0]                 key,
  output logic                                 locked,
  output logic                                 error,
  output logic                                 lockout,
  output logic [$clog2(PASSWORD_LENGTH+1)-1:0] digit_count,
  output logic [$clog2(MAX_ATTEMPTS+1)-1:0]    fail_count
);

  localparam int DIGIT_W = (KEY_WIDTH > 2) ? $clog2(KEY_WIDTH) : 1;
  localparam int CODE_W  = PASSWORD_LENGTH * DIGIT_W;
  localparam int CNT_W   = $clog2(PASSWORD_LENGTH + 1);
  localparam int FAIL_W  = $clog2(MAX_ATTEMPTS + 1);
  localparam int LK_W    = $clog2(LOCKOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    ST_UNLOCKED, ST_CREATE, ST_CONFIRM, ST_LOCKED, ST_ERROR, ST_LOCKOUT
  } state_e;

  state_e               state_q, state_d;
  logic [KEY_WIDTH-1:0] key_q, key_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 mismatch_q, mismatch_d;
  logic [CODE_W-1:0]    temp_q, temp_d;
  logic [CODE_W-1:0]    stored_q, stored_d;
  logic                 locked_q, locked_d;
  logic [FAIL_W-1:0]    fail_q, fail_d;
  logic                 error_q, error_d;
  logic [LK_W-1:0]      lk_cnt_q, lk_cnt_d;

  logic                 press, valid, last, miss;
  logic [DIGIT_W-1:0]   digit, ref_slot;
  logic [FAIL_W-1:0]    fail_inc;
  int                   slot;

`ifdef DIGITAL_LOCK_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [IDLE_W-1:0] idle_q, idle_d;
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;
`endif

  always_comb begin
    state_d    = state_q;
    key_d      = key;
    count_d    = count_q;
    mismatch_d = mismatch_q;
    temp_d     = temp_q;
    stored_d   = stored_q;
    locked_d   = locked_q;
    fail_d     = fail_q;
    error_d    = 1'b0;
    lk_cnt_d   = '0;

    press = (key_q == '0) && (key != '0);
    valid = $onehot(key);
    digit = '0;
    for (int i = 0; i < KEY_WIDTH; i++) begin
      if (key[i]) digit = DIGIT_W'(i);
    end
    slot     = int'(count_q);
    last     = (count_q == CNT_W'(PASSWORD_LENGTH - 1));
    ref_slot = (state_q == ST_LOCKED) ? stored_q[slot*DIGIT_W +: DIGIT_W]
                                      : temp_q[slot*DIGIT_W +: DIGIT_W];
    miss     = mismatch_q || !valid || (digit != ref_slot);
    fail_inc = (fail_q == FAIL_W'(MAX_ATTEMPTS)) ? fail_q : fail_q + FAIL_W'(1);

    case (state_q)
      ST_UNLOCKED: begin
        if (press && !valid) begin
          state_d = ST_ERROR;
          error_d = 1'b1;
        end else if (press) begin
          temp_d[0 +: DIGIT_W] = digit;
          if (PASSWORD_LENGTH == 1) begin
            state_d = ST_CONFIRM;
          end else begin
            state_d = ST_CREATE;
            count_d = CNT_W'(1);
          end
        end
      end
      ST_CREATE: begin
        if (press && !valid) begin
          state_d = ST_ERROR;
          error_d = 1'b1;
          count_d = '0;
        end else if (press) begin
          temp_d[slot*DIGIT_W +: DIGIT_W] = digit;
          if (last) begin
            state_d    = ST_CONFIRM;
            count_d    = '0;
            mismatch_d = 1'b0;
          end else begin
            count_d = count_q + CNT_W'(1);
          end
        end
      end
      // Confirm and unlock both compare digit-by-digit; a mismatch stays sticky until the last digit.
      ST_CONFIRM, ST_LOCKED: begin
        if (press && last) begin
          count_d    = '0;
          mismatch_d = 1'b0;
          if (!miss && state_q == ST_CONFIRM) begin
            state_d  = ST_LOCKED;
            stored_d = temp_q;
            locked_d = 1'b1;
          end else if (!miss) begin
            state_d  = ST_UNLOCKED;
            locked_d = 1'b0;
            fail_d   = '0;
          end else begin
            error_d = 1'b1;
            state_d = ST_ERROR;
            if (state_q == ST_LOCKED) begin
              fail_d = fail_inc;
              if (fail_inc == FAIL_W'(MAX_ATTEMPTS)) state_d = ST_LOCKOUT;
            end
          end
        end else if (press) begin
          count_d    = count_q + CNT_W'(1);
          mismatch_d = miss;
        end
      end
      ST_ERROR: begin
        state_d    = locked_q ? ST_LOCKED : ST_UNLOCKED;
        count_d    = '0;
        mismatch_d = 1'b0;
      end
      ST_LOCKOUT: begin
        locked_d = 1'b1;
        if (lk_cnt_q == LK_W'(LOCKOUT_CYCLES - 1)) begin
          state_d = ST_LOCKED;
          fail_d  = '0;
        end else begin
          lk_cnt_d = lk_cnt_q + LK_W'(1);
        end
      end
      default: begin
        state_d    = ST_UNLOCKED;
        locked_d   = 1'b0;
        count_d    = '0;
        mismatch_d = 1'b0;
      end
    endcase

`ifdef DIGITAL_LOCK_TIMEOUT_EN
    idle_d = (press || count_q == '0) ? '0 : idle_q + IDLE_W'(1);
    if (!press && count_q != '0 && idle_q == IDLE_W'(TIMEOUT_CYCLES - 1) &&
        (state_q inside {ST_CREATE, ST_CONFIRM, ST_LOCKED})) begin
      state_d    = ST_ERROR;
      error_d    = 1'b1;
      count_d    = '0;
      mismatch_d = 1'b0;
      idle_d     = '0;
    end
`endif
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_UNLOCKED;
      key_q      <= '0;
      count_q    <= '0;
      mismatch_q <= 1'b0;
      temp_q     <= '0;
      stored_q   <= '0;
      locked_q   <= 1'b0;
      fail_q     <= '0;
      error_q    <= 1'b0;
      lk_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      key_q      <= key_d;
      count_q    <= count_d;
      mismatch_q <= mismatch_d;
      temp_q     <= temp_d;
      stored_q   <= stored_d;
      locked_q   <= locked_d;
      fail_q     <= fail_d;
      error_q    <= error_d;
      lk_cnt_q   <= lk_cnt_d;
    end
  end

`ifdef DIGITAL_LOCK_TIMEOUT_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) idle_q <= '0;
    else       idle_q <= idle_d;
  end
`endif

  assign locked      = locked_q;
  assign error       = error_q;
  assign lockout     = (state_q == ST_LOCKOUT);
  assign digit_count = count_q;
  assign fail_count  = fail_q;

endmodule

// File: tb/tb_digital_lock_fsm.sv
// Bench for digital_lock_fsm: directed scenarios plus random key traffic against a queue-based model.
module tb_digital_lock_fsm;

  localparam int KW = 4;
  localparam int PL = 4;
  localparam int MA = 3;
  localparam int LC = 1000;
  localparam int TC = 5000;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [KW-1:0] key = '0;
  logic          locked, error, lockout;
  logic [2:0]    digit_count;
  logic [1:0]    fail_count;

  digital_lock_fsm #(
    .KEY_WIDTH(KW), .PASSWORD_LENGTH(PL), .MAX_ATTEMPTS(MA),
    .LOCKOUT_CYCLES(LC), .TIMEOUT_CYCLES(TC)
  ) dut (
    .clock(clock), .reset(reset), .key(key), .locked(locked), .error(error),
    .lockout(lockout), .digit_count(digit_count), .fail_count(fail_count)
  );

  always #5 clock = ~clock;

  typedef enum {M_OPEN, M_ENROL, M_VERIFY, M_CLOSED, M_ERR, M_BLOCK} model_phase_e;

  model_phase_e m_phase;
  int           m_entry[$], m_temp[$], m_stored[$];
  bit           m_locked, m_err;
  int           m_fails, m_block_left, m_idle;
  logic [3:0]   prev_key;
  int           test_count, fail_tally, err_cycles, lockout_cycles;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    test_count++;
    if (observed != expected) begin
      fail_tally++;
      $display("[TB] FAIL %s at %0t: got %0d, expected %0d", tag, $time, observed, expected);
    end
  endtask

  function automatic bit codesEqual(input int a[$], input int b[$]);
    if (a.size() != b.size()) return 1'b0;
    foreach (a[i]) if (a[i] != b[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int keyToDigit(input logic [3:0] k);
    if ($countones(k) != 1) return -1;
    for (int i = 0; i < 4; i++) if (k[i]) return i;
    return -1;
  endfunction

  task automatic modelReset();
    m_phase = M_OPEN;
    m_entry.delete(); m_temp.delete(); m_stored.delete();
    m_locked = 0; m_err = 0; m_fails = 0; m_block_left = 0; m_idle = 0;
    prev_key = '0;
  endtask

  task automatic modelError();
    m_phase = M_ERR;
    m_err   = 1;
    m_entry.delete();
  endtask

  // Whole-code comparison happens once the entry queue holds a full code.
  task automatic modelStep(input logic [3:0] k);
    bit press;
    int d;
    press    = (prev_key == '0) && (k != '0);
    d        = keyToDigit(k);
    prev_key = k;
    m_err    = 0;
    case (m_phase)
      M_OPEN: if (press) begin
        if (d < 0) modelError();
        else begin m_entry = '{d}; m_phase = M_ENROL; end
      end
      M_ENROL: if (press) begin
        if (d < 0) modelError();
        else begin
          m_entry.push_back(d);
          if (m_entry.size() == PL) begin
            m_temp = m_entry; m_entry.delete(); m_phase = M_VERIFY;
          end
        end
      end
      M_VERIFY: if (press) begin
        m_entry.push_back(d);
        if (m_entry.size() == PL) begin
          if (codesEqual(m_entry, m_temp)) begin
            m_stored = m_temp; m_locked = 1; m_phase = M_CLOSED; m_entry.delete();
          end else modelError();
        end
      end
      M_CLOSED: if (press) begin
        m_entry.push_back(d);
        if (m_entry.size() == PL) begin
          if (codesEqual(m_entry, m_stored)) begin
            m_locked = 0; m_fails = 0; m_phase = M_OPEN; m_entry.delete();
          end else begin
            if (m_fails < MA) m_fails++;
            if (m_fails == MA) begin
              m_phase = M_BLOCK; m_err = 1; m_block_left = LC; m_entry.delete();
            end else modelError();
          end
        end
      end
      M_ERR: m_phase = m_locked ? M_CLOSED : M_OPEN;
      M_BLOCK: begin
        m_block_left--;
        if (m_block_left == 0) begin m_phase = M_CLOSED; m_fails = 0; end
      end
      default: m_phase = M_OPEN;
    endcase
`ifdef DIGITAL_LOCK_TIMEOUT_EN
    if (!press && m_entry.size() > 0 && m_phase inside {M_ENROL, M_VERIFY, M_CLOSED}) begin
      m_idle++;
      if (m_idle == TC) begin modelError(); m_idle = 0; end
    end else m_idle = 0;
`endif
  endtask

  task automatic applyStimulus(input logic [3:0] k);
    key = k;
    @(posedge clock);
    modelStep(k);
    #1;
    checkOutput("locked", int'(locked), int'(m_locked));
    checkOutput("error", int'(error), int'(m_err));
    checkOutput("lockout", int'(lockout), int'(m_phase == M_BLOCK));
    checkOutput("digit_count", int'(digit_count), m_entry.size());
    checkOutput("fail_count", int'(fail_count), m_fails);
    if (error)   err_cycles++;
    if (lockout) lockout_cycles++;
  endtask

  task automatic doReset();
    key   = '0;
    reset = 1'b1;
    #2;
    modelReset();
    checkOutput("rst_locked", int'(locked), 0);
    checkOutput("rst_error", int'(error), 0);
    checkOutput("rst_lockout", int'(lockout), 0);
    checkOutput("rst_digit_count", int'(digit_count), 0);
    checkOutput("rst_fail_count", int'(fail_count), 0);
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic pressKey(input logic [3:0] k, input int hold, input int gap);
    repeat (hold) applyStimulus(k);
    repeat (gap) applyStimulus(4'b0000);
  endtask

  task automatic enterCode(input logic [15:0] seq);
    for (int i = 0; i < 4; i++) pressKey(seq[15-4*i -: 4], 2, 2);
  endtask

  // Biases toward the code the model expects so that successful enrol/unlock paths are exercised.
  function automatic logic [3:0] chooseKey();
    int idx, r;
    idx = m_entry.size();
    r   = $urandom_range(0, 99);
    if (r < 6 && m_phase != M_OPEN) begin
      case ($urandom_range(0, 2))
        0:       return 4'b0011;
        1:       return 4'b0101;
        default: return 4'b1111;
      endcase
    end
    if (m_phase == M_VERIFY && r < 75 && idx < m_temp.size()) return 4'b0001 << m_temp[idx];
    if (m_phase == M_CLOSED && r < 60 && idx < m_stored.size()) return 4'b0001 << m_stored[idx];
    return 4'b0001 << $urandom_range(0, 3);
  endfunction

  initial begin
    int         r, hold;
    logic [3:0] k;
    test_count = 0;
    fail_tally = 0;
    modelReset();
    #1;
    doReset();

    err_cycles = 0;
    enterCode(16'h2481);
    enterCode(16'h2482);
    checkOutput("mismatch_err_pulse", err_cycles, 1);
    checkOutput("mismatch_unlocked", int'(locked), 0);

    err_cycles = 0;
    enterCode(16'h2481);
    enterCode(16'h2481);
    checkOutput("enrol_locked", int'(locked), 1);
    checkOutput("enrol_no_error", err_cycles, 0);

    enterCode(16'h2481);
    checkOutput("unlock_locked", int'(locked), 0);
    checkOutput("unlock_fails", int'(fail_count), 0);

    enterCode(16'h2481);
    enterCode(16'h2481);
    enterCode(16'h2222);
    checkOutput("wrong1_fails", int'(fail_count), 1);
    enterCode(16'h2222);
    checkOutput("wrong2_fails", int'(fail_count), 2);
    lockout_cycles = 0;
    enterCode(16'h2222);
    for (int i = 0; i < LC + 10 && lockout; i++) applyStimulus(4'($urandom_range(0, 15)));
    applyStimulus(4'b0000);
    applyStimulus(4'b0000);
    checkOutput("lockout_length", lockout_cycles, LC);
    checkOutput("post_lockout_locked", int'(locked), 1);
    checkOutput("post_lockout_fails", int'(fail_count), 0);
    enterCode(16'h2481);
    checkOutput("post_lockout_unlock", int'(locked), 0);

    pressKey(4'b0010, 50, 2);
    checkOutput("held_key_count", int'(digit_count), 1);
    pressKey(4'b0100, 1, 1);
    pressKey(4'b1000, 1, 1);
    pressKey(4'b0001, 1, 1);
    enterCode(16'h2481);
    checkOutput("held_enrol_locked", int'(locked), 1);
    enterCode(16'h3481);
    checkOutput("nonhot_fails", int'(fail_count), 1);
    checkOutput("nonhot_locked", int'(locked), 1);

    doReset();
    pressKey(4'b0010, 1, 1);
    pressKey(4'b0100, 1, 1);
    checkOutput("two_digits", int'(digit_count), 2);
    doReset();
    pressKey(4'b0010, 1, 1);
    checkOutput("after_reset_create", int'(digit_count), 1);
    checkOutput("after_reset_locked", int'(locked), 0);

    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 99);
      if (m_phase == M_BLOCK) begin
        for (int c = 0; c < LC + 5 && m_phase == M_BLOCK; c++) applyStimulus(4'($urandom_range(0, 15)));
        applyStimulus(4'b0000);
      end else if (r < 2) begin
        doReset();
      end else begin
        k    = chooseKey();
        hold = $urandom_range(1, 3);
        applyStimulus(k);
        for (int h = 1; h < hold; h++) applyStimulus((r < 8) ? 4'($urandom_range(1, 15)) : k);
        repeat ($urandom_range(1, 2)) applyStimulus(4'b0000);
      end
    end

    $display("[TB] %0d tests run, %0d failed", test_count, fail_tally);
    $finish;
  end

endmodule
